// File: rtl/serdes_pkg.sv
// Shared types and helpers for the serial register link receive path.
package serdes_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_SHIFT  = 2'd1,
    RX_PARITY = 2'd2
  } rx_state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned MAX_WIDTH     = 64;

  // Even parity (XOR reduction) of a word zero-extended to MAX_WIDTH bits.
  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Enable-gated serial-in/parallel-out shift register with synchronous clear.
// data_c is the register's next value: the shifted word when en=1, else the held word.
module sipo_shift_reg #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] data_c
);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;

  // Shift direction is fixed at elaboration time.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign shifted = {sreg[WIDTH-2:0], d};
    end else begin : g_lsb
      assign shifted = {d, sreg[WIDTH-1:1]};
    end
  endgenerate

  // Next-value mux shared by the register and the parallel consumer.
  always_comb begin
    data_c = sreg;
    if (en) data_c = shifted;
  end

  // Shift register state.
  always_ff @(posedge clk) begin
    if (clr) sreg <= '0;
    else     sreg <= data_c;
  end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: reassembles WIDTH-bit words from a qualified 1-bit stream
// into a one-entry valid/ready output buffer with sticky overrun.
// Optional feature macro: PARITY_CHECK_EN (adds an even-parity bit per frame).
module serial_to_parallel_rx
  import serdes_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             A,
  input  logic             A_valid,
  output logic [WIDTH-1:0] Y,
  output logic             Y_valid,
  input  logic             Y_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             shift_en_c;
  logic             frame_done_c;
  logic [WIDTH-1:0] word_c;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sreg (
    .clk    (clk),
    .clr    (clr),
    .en     (shift_en_c),
    .d      (A),
    .data_c (word_c)
  );

  // FSM and bit counter registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and frame-complete decode; the first bit is taken leaving RX_IDLE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_en_c   = 1'b0;
    frame_done_c = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (A_valid) begin
          shift_en_c = 1'b1;
          cnt_d      = CNT_W'(1);
          state_d    = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        if (A_valid) begin
          shift_en_c = 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_d = '0;
`ifdef PARITY_CHECK_EN
            state_d = RX_PARITY;
`else
            state_d      = RX_IDLE;
            frame_done_c = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RX_PARITY: begin
        if (A_valid) begin
          frame_done_c = 1'b1;
          state_d      = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Output buffer: load on frame complete if empty or draining, else drop and flag overrun.
  always_ff @(posedge clk) begin
    if (clr) begin
      Y          <= '0;
      Y_valid    <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else if (frame_done_c) begin
      if (!Y_valid || Y_ready) begin
        Y       <= word_c;
        Y_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
        parity_err <= even_parity(MAX_WIDTH'(word_c)) ^ A;
`else
        parity_err <= 1'b0;
`endif
      end else begin
        overrun <= 1'b1;
      end
    end else if (Y_valid && Y_ready) begin
      Y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx: per-cycle vector table on an MSB-first
// instance plus a hand-driven back-to-back sequence on an LSB-first instance.
module tb_serial_to_parallel_rx;

  logic       clk = 1'b0;
  logic       clr, a, av, rdy;
  logic [3:0] y;
  logic       yv, ov, pe;
  logic       a2, av2, rdy2;
  logic [3:0] y2;
  logic       yv2, ov2, pe2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       clr;
    logic       a;
    logic       av;
    logic       rdy;
    logic [3:0] ey;
    logic       ev;
    logic       eo;
    logic       ep;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  serial_to_parallel_rx #(.WIDTH(4), .MSB_FIRST(1)) dut (
    .clk(clk), .clr(clr), .A(a), .A_valid(av), .Y(y), .Y_valid(yv),
    .Y_ready(rdy), .overrun(ov), .parity_err(pe)
  );

  serial_to_parallel_rx #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .clr(clr), .A(a2), .A_valid(av2), .Y(y2), .Y_valid(yv2),
    .Y_ready(rdy2), .overrun(ov2), .parity_err(pe2)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Row: inputs for one posedge, expected outputs just after it.
  task automatic add(input logic c, input logic ai, input logic avi, input logic r,
                     input logic [3:0] ey, input logic ev, input logic eo, input logic ep);
    vec_t v;
    v.clr = c; v.a = ai; v.av = avi; v.rdy = r;
    v.ey = ey; v.ev = ev; v.eo = eo; v.ep = ep;
    tbl.push_back(v);
  endtask

  // LSB-first frame on dut_lsb; seq[3] is sent first. Checks the word at completion.
  task automatic send_lsb(input logic [3:0] seq, input logic [3:0] exp, input string name);
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      a2 = seq[i]; av2 = 1'b1;
    end
`ifdef PARITY_CHECK_EN
    @(negedge clk);
    a2 = ^seq;
`endif
    @(posedge clk); #1;
    chk({name, ".y"}, y2, exp);
    chk({name, ".valid"}, {3'b0, yv2}, 4'b0001);
    chk({name, ".perr"}, {3'b0, pe2}, 4'b0000);
  endtask

  initial begin
    clr = 1'b0; a = 1'b0; av = 1'b0; rdy = 1'b0;
    a2 = 1'b0; av2 = 1'b0; rdy2 = 1'b1;

    // reset
    add(1, 0, 0, 0, 4'b0000, 0, 0, 0);
`ifndef PARITY_CHECK_EN
    // 0,0,1,1 with ready high: one-cycle valid
    add(0, 0, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 0, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 1, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 1, 1, 1, 4'b0011, 1, 0, 0);
    add(0, 0, 0, 1, 4'b0011, 0, 0, 0);
    // same bits with a 3-cycle gap after bit 2
    add(0, 0, 1, 1, 4'b0011, 0, 0, 0);
    add(0, 0, 1, 1, 4'b0011, 0, 0, 0);
    add(0, 1, 0, 1, 4'b0011, 0, 0, 0);
    add(0, 1, 0, 1, 4'b0011, 0, 0, 0);
    add(0, 1, 0, 1, 4'b0011, 0, 0, 0);
    add(0, 1, 1, 1, 4'b0011, 0, 0, 0);
    add(0, 1, 1, 1, 4'b0011, 1, 0, 0);
    add(0, 0, 0, 1, 4'b0011, 0, 0, 0);
    // ready low: 1,0,1,0 then 1,1,1,1 -> overrun, word kept
    add(0, 1, 1, 0, 4'b0011, 0, 0, 0);
    add(0, 0, 1, 0, 4'b0011, 0, 0, 0);
    add(0, 1, 1, 0, 4'b0011, 0, 0, 0);
    add(0, 0, 1, 0, 4'b1010, 1, 0, 0);
    add(0, 1, 1, 0, 4'b1010, 1, 0, 0);
    add(0, 1, 1, 0, 4'b1010, 1, 0, 0);
    add(0, 1, 1, 0, 4'b1010, 1, 0, 0);
    add(0, 1, 1, 0, 4'b1010, 1, 1, 0);
    add(0, 0, 0, 1, 4'b1010, 0, 1, 0);
    add(0, 0, 0, 1, 4'b1010, 0, 1, 0);
    // partial word 1,1 then clr, then 0,1,0,1
    add(0, 1, 1, 1, 4'b1010, 0, 1, 0);
    add(0, 1, 1, 1, 4'b1010, 0, 1, 0);
    add(1, 0, 0, 1, 4'b0000, 0, 0, 0);
    add(0, 0, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 1, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 0, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 1, 1, 1, 4'b0101, 1, 0, 0);
    add(0, 0, 0, 1, 4'b0101, 0, 0, 0);
    // full buffer drained and refilled on the same edge
    add(0, 1, 1, 0, 4'b0101, 0, 0, 0);
    add(0, 1, 1, 0, 4'b0101, 0, 0, 0);
    add(0, 0, 1, 0, 4'b0101, 0, 0, 0);
    add(0, 0, 1, 0, 4'b1100, 1, 0, 0);
    add(0, 0, 1, 0, 4'b1100, 1, 0, 0);
    add(0, 1, 1, 0, 4'b1100, 1, 0, 0);
    add(0, 1, 1, 0, 4'b1100, 1, 0, 0);
    add(0, 0, 1, 1, 4'b0110, 1, 0, 0);
    add(0, 0, 0, 1, 4'b0110, 0, 0, 0);
`else
    // 1,0,1,1 + parity 1: good parity
    add(0, 1, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 0, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 1, 0, 4'b1011, 1, 0, 0);
    // same data + parity 0: parity error; first bit drains the buffer
    add(0, 1, 1, 1, 4'b1011, 0, 0, 0);
    add(0, 0, 1, 1, 4'b1011, 0, 0, 0);
    add(0, 1, 1, 1, 4'b1011, 0, 0, 0);
    add(0, 1, 1, 1, 4'b1011, 0, 0, 0);
    add(0, 0, 1, 1, 4'b1011, 1, 0, 1);
    add(0, 0, 0, 1, 4'b1011, 0, 0, 1);
    // 0,0,0,1 + parity 1 held, then 1,1,1,1 + 0 dropped at the parity edge
    add(0, 0, 1, 0, 4'b1011, 0, 0, 1);
    add(0, 0, 1, 0, 4'b1011, 0, 0, 1);
    add(0, 0, 1, 0, 4'b1011, 0, 0, 1);
    add(0, 1, 1, 0, 4'b1011, 0, 0, 1);
    add(0, 1, 1, 0, 4'b0001, 1, 0, 0);
    add(0, 1, 1, 0, 4'b0001, 1, 0, 0);
    add(0, 1, 1, 0, 4'b0001, 1, 0, 0);
    add(0, 1, 1, 0, 4'b0001, 1, 0, 0);
    add(0, 1, 1, 0, 4'b0001, 1, 0, 0);
    add(0, 0, 1, 0, 4'b0001, 1, 1, 0);
    add(0, 0, 0, 1, 4'b0001, 0, 1, 0);
`endif

    foreach (tbl[i]) begin
      @(negedge clk);
      clr = tbl[i].clr; a = tbl[i].a; av = tbl[i].av; rdy = tbl[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("row%0d.y", i), y, tbl[i].ey);
      chk($sformatf("row%0d.valid", i), {3'b0, yv}, {3'b0, tbl[i].ev});
      chk($sformatf("row%0d.overrun", i), {3'b0, ov}, {3'b0, tbl[i].eo});
      chk($sformatf("row%0d.perr", i), {3'b0, pe}, {3'b0, tbl[i].ep});
    end

    // LSB-first instance, back-to-back frames with ready held high
    @(negedge clk);
    clr = 1'b0; av = 1'b0; rdy = 1'b0;
    send_lsb(4'b1000, 4'b0001, "lsb0");
    send_lsb(4'b0110, 4'b0110, "lsb1");
    send_lsb(4'b1101, 4'b1011, "lsb2");
    @(negedge clk);
    av2 = 1'b0;
    @(posedge clk); #1;
    chk("lsb.drain", {3'b0, yv2}, 4'b0000);
    chk("lsb.overrun", {3'b0, ov2}, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
